// File: rtl/gpr_wb_ctrl.sv
// gpr_wb_ctrl -- writeback controller for the GPR file write port.
//
// Merges two result sources onto the single GPR write port:
//   * fast port: the single-cycle pipeline result, which the pipeline holds
//     steady while fw_stall_O is high.
//   * slow port: multi-cycle unit results (mult/div/mfhi/mflo), buffered in
//     a DEPTH-entry FIFO and written back in arrival order.
// A pending-register scoreboard (pending_O) lets decode stall on RAW hazards
// against results still owed by the slow units.
//
// Ports
//   clk_I, clr_n_I           clock, asynchronous active-low reset
//   fw_valid_I/reg_I/data_I  fast result; fw_stall_O = not taken this cycle
//   sw_valid_I/reg_I/data_I  slow result; accepted when sw_ready_O is high
//   rsv_valid_I/rsv_reg_I    decode reserves a register for a slow op
//   pending_O                bit r set = slow write to r outstanding
//   RegWrite_O/Wreg_O/WD_O   registered GPR write port (GPR latches on negedge)
//
// Handshake: a slow result transfers on a posedge where sw_valid_I and
// sw_ready_O are both high; the producer must hold sw_* stable otherwise.
// The fast result transfers on any posedge where fw_valid_I is high and
// fw_stall_O is low; when stalled, the pipeline holds fw_* stable.
module gpr_wb_ctrl #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk_I,
    input  logic        clr_n_I,
    input  logic        fw_valid_I,
    input  logic [4:0]  fw_reg_I,
    input  logic [31:0] fw_data_I,
    output logic        fw_stall_O,
    input  logic        sw_valid_I,
    output logic        sw_ready_O,
    input  logic [4:0]  sw_reg_I,
    input  logic [31:0] sw_data_I,
    input  logic        rsv_valid_I,
    input  logic [4:0]  rsv_reg_I,
    output logic [31:0] pending_O,
    output logic        RegWrite_O,
    output logic [4:0]  Wreg_O,
    output logic [31:0] WD_O
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    // FIFO: pointers carry one extra wrap bit so full and empty differ.
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [36:0]   mem_q [DEPTH];
    logic [36:0]   head;
    logic [4:0]    head_reg;
    logic          empty, full, full_d;
    logic          push, pop;

    logic          slow_win, fast_win;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0]   pend_q, pend_d;
    logic          ready_q;

    logic          regwrite_q, regwrite_d;
    logic [4:0]    wreg_q, wreg_d;
    logic [31:0]   wd_q, wd_d;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign head_reg = head[36:32];

    // Slow results win when the FIFO is full, when the fast port has had
    // STARVE_MAX consecutive wins over a non-empty FIFO, or when fast is idle.
    assign slow_win = !empty && (full || (starve_q == STARVE_LIM) || !fw_valid_I);
    assign fast_win = fw_valid_I && !slow_win;
    assign pop      = slow_win;
    // ready_q is registered from the next pointer state, so a pop in the same
    // cycle never opens a slot in a full FIFO.
    assign push     = sw_valid_I && ready_q;

    assign fw_stall_O = fw_valid_I && slow_win;
    assign sw_ready_O = ready_q;
    assign pending_O  = pend_q;
    assign RegWrite_O = regwrite_q;
    assign Wreg_O     = wreg_q;
    assign WD_O       = wd_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pend_d     = pend_q;
        regwrite_d = 1'b0;
        wreg_d     = wreg_q;
        wd_d       = wd_q;
        starve_d   = '0;

        if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);

        // A write to $0 still consumes the slot but never enables the GPR.
        if (slow_win) begin
            regwrite_d = (head_reg != 5'd0);
            wreg_d     = head_reg;
            wd_d       = head[31:0];
            pend_d[head_reg] = 1'b0;
        end else if (fast_win) begin
            regwrite_d = (fw_reg_I != 5'd0);
            wreg_d     = fw_reg_I;
            wd_d       = fw_data_I;
        end

        // Count only fast wins that bypass a waiting slow result.
        if (fast_win && !empty) begin
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + SW'(1);
        end

        // A reservation applied after the pop-clear makes set win on a tie.
        if (rsv_valid_I && (rsv_reg_I != 5'd0)) pend_d[rsv_reg_I] = 1'b1;

        full_d = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                 (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    always_ff @(posedge clk_I or negedge clr_n_I) begin
        if (!clr_n_I) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            starve_q   <= '0;
            pend_q     <= '0;
            ready_q    <= 1'b0;
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wd_q       <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            starve_q   <= starve_d;
            pend_q     <= pend_d;
            ready_q    <= !full_d;
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wd_q       <= wd_d;
        end
    end

    // Entry storage needs no reset: occupancy is tracked by the pointers.
    always_ff @(posedge clk_I) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {sw_reg_I, sw_data_I};
    end

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
module tb_gpr_wb_ctrl;
  localparam int DEPTH = 4;
  localparam int STARVE_MAX = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr_n = 1'b1;
  always #5 clk = ~clk;

  logic        fw_valid = 1'b0;
  logic [4:0]  fw_reg = '0;
  logic [31:0] fw_data = '0;
  logic        fw_stall_O;
  logic        sw_valid = 1'b0;
  logic        sw_ready_O;
  logic [4:0]  sw_reg = '0;
  logic [31:0] sw_data = '0;
  logic        rsv_valid = 1'b0;
  logic [4:0]  rsv_reg = '0;
  logic [31:0] pending_O;
  logic        RegWrite_O;
  logic [4:0]  Wreg_O;
  logic [31:0] WD_O;

  gpr_wb_ctrl #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_I(clk), .clr_n_I(clr_n),
    .fw_valid_I(fw_valid), .fw_reg_I(fw_reg), .fw_data_I(fw_data), .fw_stall_O(fw_stall_O),
    .sw_valid_I(sw_valid), .sw_ready_O(sw_ready_O), .sw_reg_I(sw_reg), .sw_data_I(sw_data),
    .rsv_valid_I(rsv_valid), .rsv_reg_I(rsv_reg), .pending_O(pending_O),
    .RegWrite_O(RegWrite_O), .Wreg_O(Wreg_O), .WD_O(WD_O)
  );

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad = 0;

  logic [36:0] exp_q[$];    // slow results owed to the GPR, oldest first
  int          m_starve;    // fast wins in a row while slow results wait
  logic        m_ready;
  logic        m_stall;
  logic        m_pushed;
  logic [31:0] m_pend;
  logic        m_rw;
  logic [4:0]  m_wreg;
  logic [31:0] m_wd;
  logic        last_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_starve = 0;
    m_ready  = 1'b0;
    m_stall  = 1'b0;
    m_pushed = 1'b0;
    m_pend   = '0;
    m_rw     = 1'b0;
    m_wreg   = '0;
    m_wd     = '0;
  endtask

  // One clock cycle: called at a negedge with inputs already driven.
  // Checks the combinational outputs mid-cycle and the registered outputs
  // just after the posedge, then returns at the next negedge.
  task automatic step();
    logic        nonempty, is_full, swin, fwin, pushm;
    logic [36:0] head;
    #1;
    nonempty = (exp_q.size() > 0);
    is_full  = (exp_q.size() == DEPTH);
    swin = nonempty && (is_full || m_starve == STARVE_MAX || !fw_valid);
    fwin = fw_valid && !swin;
    m_stall = fw_valid && swin;
    pushm = sw_valid && m_ready;
    last_stall = fw_stall_O;
    chk("sw_ready", 32'(sw_ready_O), 32'(m_ready));
    chk("fw_stall", 32'(fw_stall_O), 32'(m_stall));
    @(posedge clk);
    if (swin) begin
      head = exp_q.pop_front();
      m_rw = (head[36:32] != 5'd0);
      m_wreg = head[36:32];
      m_wd = head[31:0];
      m_pend[head[36:32]] = 1'b0;
    end else if (fwin) begin
      m_rw = (fw_reg != 5'd0);
      m_wreg = fw_reg;
      m_wd = fw_data;
    end else begin
      m_rw = 1'b0;
    end
    if (fwin && nonempty) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
    else m_starve = 0;
    if (rsv_valid && rsv_reg != 5'd0) m_pend[rsv_reg] = 1'b1;
    if (pushm) exp_q.push_back({sw_reg, sw_data});
    m_pushed = pushm;
    m_ready = (exp_q.size() < DEPTH);
    #1;
    chk("RegWrite", 32'(RegWrite_O), 32'(m_rw));
    chk("Wreg", 32'(Wreg_O), 32'(m_wreg));
    chk("WD", WD_O, m_wd);
    chk("pending", pending_O, m_pend);
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    fw_valid = 1'b0;
    sw_valid = 1'b0;
    rsv_valid = 1'b0;
  endtask

  // Asserts reset wherever the caller is in the cycle, checks the outputs
  // clear at once, holds across a posedge, and releases at a negedge.
  task automatic do_reset();
    clr_n = 1'b0;
    #1;
    chk("rst_pending", pending_O, 32'h0);
    chk("rst_RegWrite", 32'(RegWrite_O), 32'h0);
    chk("rst_Wreg", 32'(Wreg_O), 32'h0);
    chk("rst_WD", WD_O, 32'h0);
    chk("rst_fw_stall", 32'(fw_stall_O), 32'h0);
    chk("rst_sw_ready", 32'(sw_ready_O), 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_held_ready", 32'(sw_ready_O), 32'h0);
    clr_n = 1'b1;
  endtask

  task automatic drain();
    set_idle();
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) step();
    chk("drain_empty", 32'(exp_q.size()), 32'h0);
  endtask

  function automatic logic [4:0] rand_reg();
    return 5'($urandom_range(0, 7));
  endfunction

  logic exp_st[5];

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    #2;
    do_reset();
    set_idle();
    step();
    chk("ready_after_release", 32'(sw_ready_O), 32'h1);

    // 1: reset with two slow results queued and regs 8, 9 reserved
    fw_valid = 1'b1; fw_reg = 5'd1; fw_data = 32'h1111;
    sw_valid = 1'b1; sw_reg = 5'd8; sw_data = 32'h88;
    rsv_valid = 1'b1; rsv_reg = 5'd8;
    step();
    fw_reg = 5'd2; sw_reg = 5'd9; sw_data = 32'h99; rsv_reg = 5'd9;
    step();
    chk("t1_pending", pending_O, 32'h0000_0300);
    chk("t1_depth", 32'(exp_q.size()), 32'h2);
    set_idle();
    #2;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_no_write", 32'(RegWrite_O), 32'h0);
    end

    // 2: fast only, then a fast write to $0
    fw_valid = 1'b1; fw_reg = 5'd5; fw_data = 32'hDEADBEEF;
    step();
    chk("t2_stall", 32'(last_stall), 32'h0);
    chk("t2_rw", 32'(RegWrite_O), 32'h1);
    chk("t2_wreg", 32'(Wreg_O), 32'h5);
    chk("t2_wd", WD_O, 32'hDEADBEEF);
    fw_reg = 5'd0; fw_data = 32'h5555;
    step();
    chk("t2_r0_rw", 32'(RegWrite_O), 32'h0);

    // 3: reserve, push, pop of reg 8
    set_idle();
    rsv_valid = 1'b1; rsv_reg = 5'd8;
    step();
    chk("t3_pend_set", 32'(pending_O[8]), 32'h1);
    rsv_valid = 1'b0;
    sw_valid = 1'b1; sw_reg = 5'd8; sw_data = 32'h1234;
    step();
    chk("t3_pend_hold", 32'(pending_O[8]), 32'h1);
    chk("t3_no_write", 32'(RegWrite_O), 32'h0);
    sw_valid = 1'b0;
    step();
    chk("t3_rw", 32'(RegWrite_O), 32'h1);
    chk("t3_wreg", 32'(Wreg_O), 32'h8);
    chk("t3_wd", WD_O, 32'h1234);
    chk("t3_pend_clr", 32'(pending_O[8]), 32'h0);

    // 4: starvation limit with one queued slow result
    fw_valid = 1'b1; fw_reg = 5'd3; fw_data = 32'hA1;
    sw_valid = 1'b1; sw_reg = 5'd10; sw_data = 32'hAAAA;
    step();
    sw_valid = 1'b0;
    exp_st = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      if (i == 0 || !last_stall) begin
        fw_reg = 5'(11 + i);
        fw_data = 32'hF000_0000 + 32'(i);
      end
      step();
      chk("t4_stall", 32'(last_stall), 32'(exp_st[i]));
      if (i == 3) begin
        chk("t4_slow_wreg", 32'(Wreg_O), 32'd10);
        chk("t4_slow_wd", WD_O, 32'hAAAA);
      end
    end
    chk("t4_resume_wreg", 32'(Wreg_O), 32'd14);
    chk("t4_resume_wd", WD_O, 32'hF000_0003);
    drain();

    // 5: fill the FIFO while the fast port is busy
    fw_valid = 1'b1; sw_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fw_reg = 5'(1 + i); fw_data = 32'hC000_0000 + 32'(i);
      sw_reg = 5'(16 + i); sw_data = 32'hB000_0000 + 32'(i);
      step();
      chk("t5_fill_stall", 32'(last_stall), 32'h0);
    end
    chk("t5_ready_low", 32'(sw_ready_O), 32'h0);
    fw_reg = 5'd6; fw_data = 32'hC000_0006;
    sw_reg = 5'd20; sw_data = 32'hB000_0020;
    step();
    chk("t5_full_stall", 32'(last_stall), 32'h1);
    chk("t5_slow_wreg", 32'(Wreg_O), 32'd16);
    chk("t5_ready_back", 32'(sw_ready_O), 32'h1);
    step();
    chk("t5_held_wreg", 32'(Wreg_O), 32'd6);
    drain();

    // 6: reserve and pop of the same register in one cycle
    set_idle();
    rsv_valid = 1'b1; rsv_reg = 5'd9;
    sw_valid = 1'b1; sw_reg = 5'd9; sw_data = 32'h9999;
    step();
    sw_valid = 1'b0;
    step();
    chk("t6_wreg", 32'(Wreg_O), 32'd9);
    chk("t6_pend", 32'(pending_O[9]), 32'h1);
    set_idle();
    step();
    chk("t6_pend_kept", 32'(pending_O[9]), 32'h1);

    // random traffic against the model, with one reset in the middle
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) begin
        #2;
        do_reset();
      end
      if (!m_stall) begin
        fw_valid = ($urandom_range(0, 9) < 7);
        fw_reg = rand_reg();
        fw_data = $urandom();
      end
      if (!(sw_valid && !m_pushed)) begin
        sw_valid = ($urandom_range(0, 9) < 4);
        sw_reg = rand_reg();
        sw_data = $urandom();
      end
      rsv_valid = ($urandom_range(0, 4) == 0);
      rsv_reg = rand_reg();
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
